// File: rtl/weight_dump_streamer.sv
// Streams every weight of a three-layer MLP out of the weight RAM as
// (layer, address, data) words over a valid/ready handshake.
// Optional feature: define WEIGHT_DUMP_CHECKSUM_EN for an XOR checksum of the dump.
module weight_dump_streamer #(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    output logic                            o_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_rd_data,
    output logic                            o_weight_valid,
    input  logic                            i_weight_ready,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [DATA_WIDTH-1:0]           o_checksum
);

    // Word counts per layer: each node carries its inputs plus one bias.
    localparam int unsigned CNT_L1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
    localparam int unsigned CNT_L2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int unsigned CNT_L3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

    localparam logic [LAYER_WIDTH-1:0] LAYER_FIRST = LAYER_WIDTH'(1);
    localparam logic [LAYER_WIDTH-1:0] LAYER_LAST  = LAYER_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [LAYER_WIDTH-1:0]            layer_q, layer_d;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   addr_q, addr_d;
    logic                              rd_en_q, rd_en_d;
    logic [LAYER_WIDTH-1:0]            rd_layer_q, rd_layer_d;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                              weight_valid_q, weight_valid_d;
    logic [LAYER_WIDTH-1:0]            weight_layer_q, weight_layer_d;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   weight_addr_q, weight_addr_d;
    logic [DATA_WIDTH-1:0]             weight_q, weight_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]             checksum_q, checksum_d;
`endif

    logic [WEIGHT_COUNTER_WIDTH-1:0]   last_addr;
    logic [LAYER_WIDTH-1:0]            next_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   next_addr;

    // Final address of the layer currently being dumped.
    always_comb begin
        last_addr = '0;
        case (layer_q)
            LAYER_WIDTH'(1): last_addr = WEIGHT_COUNTER_WIDTH'(CNT_L1 - 1);
            LAYER_WIDTH'(2): last_addr = WEIGHT_COUNTER_WIDTH'(CNT_L2 - 1);
            LAYER_WIDTH'(3): last_addr = WEIGHT_COUNTER_WIDTH'(CNT_L3 - 1);
            default:         last_addr = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        addr_d         = addr_q;
        rd_en_d        = 1'b0;
        rd_layer_d     = rd_layer_q;
        rd_addr_d      = rd_addr_q;
        weight_valid_d = weight_valid_q;
        weight_layer_d = weight_layer_q;
        weight_addr_d  = weight_addr_q;
        weight_d       = weight_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        next_layer     = layer_q;
        next_addr      = addr_q + WEIGHT_COUNTER_WIDTH'(1);
`ifdef WEIGHT_DUMP_CHECKSUM_EN
        checksum_d     = checksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_READ;
                    layer_d    = LAYER_FIRST;
                    addr_d     = '0;
                    rd_en_d    = 1'b1;
                    rd_layer_d = LAYER_FIRST;
                    rd_addr_d  = '0;
                    busy_d     = 1'b1;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d        = S_SEND;
                weight_d       = i_rd_data;
                weight_layer_d = layer_q;
                weight_addr_d  = addr_q;
                weight_valid_d = 1'b1;
            end
            S_SEND: begin
                if (i_weight_ready) begin
                    weight_valid_d = 1'b0;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
                    checksum_d     = checksum_q ^ weight_q;
`endif
                    if (addr_q == last_addr) begin
                        next_layer = layer_q + LAYER_WIDTH'(1);
                        next_addr  = '0;
                    end
                    if ((addr_q == last_addr) && (layer_q == LAYER_LAST)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = S_READ;
                        layer_d    = next_layer;
                        addr_d     = next_addr;
                        rd_en_d    = 1'b1;
                        rd_layer_d = next_layer;
                        rd_addr_d  = next_addr;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            layer_q        <= '0;
            addr_q         <= '0;
            rd_en_q        <= 1'b0;
            rd_layer_q     <= '0;
            rd_addr_q      <= '0;
            weight_valid_q <= 1'b0;
            weight_layer_q <= '0;
            weight_addr_q  <= '0;
            weight_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            addr_q         <= addr_d;
            rd_en_q        <= rd_en_d;
            rd_layer_q     <= rd_layer_d;
            rd_addr_q      <= rd_addr_d;
            weight_valid_q <= weight_valid_d;
            weight_layer_q <= weight_layer_d;
            weight_addr_q  <= weight_addr_d;
            weight_q       <= weight_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

    assign o_rd_en        = rd_en_q;
    assign o_rd_layer     = rd_layer_q;
    assign o_rd_addr      = rd_addr_q;
    assign o_weight_valid = weight_valid_q;
    assign o_weight_layer = weight_layer_q;
    assign o_weight_addr  = weight_addr_q;
    assign o_weight       = weight_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
    assign o_checksum     = checksum_q;
`else
    assign o_checksum     = '0;
`endif

endmodule

// File: tb/tb_weight_dump_streamer.sv
// Scoreboard bench for weight_dump_streamer: expected (layer, addr) words are
// queued at start and popped as the DUT hands them over.
module tb_weight_dump_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_rd_en;
    logic [1:0]  o_rd_layer;
    logic [10:0] o_rd_addr;
    logic [31:0] i_rd_data = '0;
    logic        o_weight_valid;
    logic        i_weight_ready = 1'b0;
    logic [1:0]  o_weight_layer;
    logic [10:0] o_weight_addr;
    logic [31:0] o_weight;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_checksum;

    int          errors = 0;
    int          checks = 0;
    logic        ram_const = 1'b0;
    logic [12:0] sb_q[$];

    weight_dump_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_rd_en        (o_rd_en),
        .o_rd_layer     (o_rd_layer),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (i_rd_data),
        .o_weight_valid (o_weight_valid),
        .i_weight_ready (i_weight_ready),
        .o_weight_layer (o_weight_layer),
        .o_weight_addr  (o_weight_addr),
        .o_weight       (o_weight),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_checksum     (o_checksum)
    );

    always #5 clk = ~clk;

    // Weight RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (o_rd_en)
            i_rd_data <= ram_const ? 32'h3F800000 : {o_rd_layer, 19'b0, o_rd_addr};
    end

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({o_rd_en, o_weight_valid, o_busy, o_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 0000", {o_rd_en, o_weight_valid, o_busy, o_done});
        end
        checks++;
        if ({o_rd_layer, o_rd_addr, o_weight_layer, o_weight_addr} !== 26'b0) begin
            errors++;
            $display("FAIL reset_addr: got %h exp 0", {o_rd_layer, o_rd_addr, o_weight_layer, o_weight_addr});
        end
        checks++;
        if (o_weight !== 32'h0) begin
            errors++;
            $display("FAIL reset_weight: got %h exp 0", o_weight);
        end
        checks++;
        if (o_checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_checksum: got %h exp 0", o_checksum);
        end
    endtask

    // Full dump with ready asserted pct% of cycles; optional ignored re-start.
    task automatic test_stream(input int pct, input int restart_word, input string name);
        int          acc = 0;
        int          done_cnt = 0;
        int          cyc = 0;
        int          last_acc = -1;
        int          done_edge = -1;
        int          limit = (pct >= 100) ? 5000 : 20000;
        logic        prev_stall = 1'b0;
        logic        prev_rd = 1'b0;
        logic        restarted = 1'b0;
        logic [44:0] held = '0;

        sb_q.delete();
        for (int i = 0; i < 96; i++)   sb_q.push_back({2'b01, 11'(i)});
        for (int i = 0; i < 1056; i++) sb_q.push_back({2'b10, 11'(i)});
        for (int i = 0; i < 99; i++)   sb_q.push_back({2'b11, 11'(i)});

        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        i_start = 1'b0;

        while (cyc < limit && !(done_edge >= 0 && cyc > done_edge + 3)) begin
            i_weight_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            i_start = 1'b0;
            if (restart_word >= 0 && !restarted && acc == restart_word) begin
                i_start   = 1'b1;
                restarted = 1'b1;
            end

            if (o_rd_en) begin
                checks++;
                if (prev_rd) begin
                    errors++;
                    $display("FAIL %s rd_en_width: rd_en high two cycles at cyc %0d", name, cyc);
                end
                checks++;
                if (sb_q.size() == 0 || {o_rd_layer, o_rd_addr} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL %s rd_addr: got %h exp %h", name, {o_rd_layer, o_rd_addr},
                             (sb_q.size() > 0) ? sb_q[0] : 13'h1fff);
                end
            end
            prev_rd = o_rd_en;

            if (prev_stall) begin
                checks++;
                if ({o_weight_valid, o_weight_layer, o_weight_addr, o_weight} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL %s stall_stable: got %b_%h exp 1_%h", name, o_weight_valid,
                             {o_weight_layer, o_weight_addr, o_weight}, held);
                end
            end
            prev_stall = 1'b0;

            if (o_weight_valid) begin
                checks++;
                if (o_weight !== {o_weight_layer, 19'b0, o_weight_addr}) begin
                    errors++;
                    $display("FAIL %s data: got %h exp %h", name, o_weight,
                             {o_weight_layer, 19'b0, o_weight_addr});
                end
                if (i_weight_ready) begin
                    checks++;
                    if (sb_q.size() == 0 || {o_weight_layer, o_weight_addr} !== sb_q[0]) begin
                        errors++;
                        $display("FAIL %s order: got %h exp %h", name, {o_weight_layer, o_weight_addr},
                                 (sb_q.size() > 0) ? sb_q[0] : 13'h1fff);
                    end
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    acc++;
                    last_acc = cyc + 1;
                end else begin
                    prev_stall = 1'b1;
                    held = {o_weight_layer, o_weight_addr, o_weight};
                end
            end

            if (sb_q.size() > 0) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b exp 1 at cyc %0d", name, o_busy, cyc);
                end
            end

            if (o_done) begin
                done_cnt++;
                done_edge = cyc + 1;
                checks++;
                if (sb_q.size() != 0 || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_early: remaining %0d busy %b exp 0 0", name, sb_q.size(), o_busy);
                end
            end

            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        i_start = 1'b0;

        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d exp 1 (cycles %0d)", name, done_cnt, cyc);
        end
        checks++;
        if (acc != 1251 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s word_count: got %0d exp 1251 remaining %0d", name, acc, sb_q.size());
        end
        if (pct >= 100) begin
            checks++;
            if (last_acc != 3753) begin
                errors++;
                $display("FAIL %s last_accept_cycle: got %0d exp 3753", name, last_acc);
            end
            checks++;
            if (done_edge != 3754) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d exp 3754", name, done_edge);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc = 0;
        int cyc = 0;

        i_weight_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (acc < 600 && cyc < 3000) begin
            if (o_weight_valid) acc++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (acc != 600) begin
            errors++;
            $display("FAIL mid_reset_reach: got %0d words exp 600", acc);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({o_rd_en, o_weight_valid, o_busy, o_done} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b exp 0000", {o_rd_en, o_weight_valid, o_busy, o_done});
        end
        checks++;
        if ({o_rd_layer, o_rd_addr, o_weight_layer, o_weight_addr, o_weight, o_checksum} !== 90'b0) begin
            errors++;
            $display("FAIL mid_reset_data: got %h exp 0",
                     {o_rd_layer, o_rd_addr, o_weight_layer, o_weight_addr, o_weight, o_checksum});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({o_done, o_weight_valid, o_rd_en} !== 3'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: got %b exp 000", {o_done, o_weight_valid, o_rd_en});
            end
        end

        i_weight_ready = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if ({o_rd_en, o_rd_layer, o_rd_addr} !== {1'b1, 2'b01, 11'd0}) begin
            errors++;
            $display("FAIL restart_read: got %h exp %h", {o_rd_en, o_rd_layer, o_rd_addr}, {1'b1, 2'b01, 11'd0});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({o_weight_valid, o_weight_layer, o_weight_addr, o_weight} !== {1'b1, 2'b01, 11'd0, 32'h40000000}) begin
            errors++;
            $display("FAIL restart_word: got %h exp %h", {o_weight_valid, o_weight_layer, o_weight_addr, o_weight},
                     {1'b1, 2'b01, 11'd0, 32'h40000000});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_checksum;
        int          cyc = 0;
        logic        seen = 1'b0;
        logic [31:0] exp_sum;
`ifdef WEIGHT_DUMP_CHECKSUM_EN
        exp_sum = 32'h3F800000;
`else
        exp_sum = 32'h0;
`endif
        ram_const = 1'b1;
        i_weight_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (!seen && cyc < 5000) begin
            if (o_done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!seen || o_checksum !== exp_sum) begin
            errors++;
            $display("FAIL checksum_done: done %b got %h exp %h", seen, o_checksum, exp_sum);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_checksum !== exp_sum) begin
            errors++;
            $display("FAIL checksum_hold: got %h exp %h", o_checksum, exp_sum);
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_checksum !== 32'h0) begin
            errors++;
            $display("FAIL checksum_clear: got %h exp 0", o_checksum);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ram_const = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset;
        rst = 1'b0;
        test_stream(100, -1, "full");
        test_stream(50, -1, "random_ready");
        test_stream(100, 500, "restart_ignored");
        test_reset_mid;
        test_stream(100, -1, "after_reset");
        test_checksum;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
